// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit with shift-add multiply and restoring divide on magnitudes.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] dInA,
  input  logic [WIDTH-1:0] dInB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  state_t state_reg, state_next;

  logic [CW-1:0]        cnt_reg;
  logic                 div_reg, neg_q_reg, neg_r_reg, done_reg;
  logic [WIDTH-1:0]     a_reg, b_reg, hi_reg, lo_reg;
  logic [2*WIDTH-1:0]   acc_reg, acc_next;

  logic                 accept, last_step, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, div_shift;
  logic [WIDTH-1:0]     div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   prod_mag, prod;
  logic [WIDTH-1:0]     quo, rem, res_hi, res_lo;

  assign accept    = start && (state_reg == IDLE) && !MDOp[2];
  assign last_step = (state_reg == RUN) && (cnt_reg == LAST_STEP);
  assign a_neg     = !MDOp[0] && dInA[WIDTH-1];
  assign b_neg     = !MDOp[0] && dInB[WIDTH-1];
  assign a_mag     = a_neg ? -dInA : dInA;
  assign b_mag     = b_neg ? -dInB : dInB;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (cnt_reg == LAST_STEP) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // acc_reg holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){acc_reg[0]}} & {1'b0, b_reg});
    div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
    div_ge    = div_shift >= {1'b0, b_reg};
    div_diff  = div_shift[WIDTH-1:0] - b_reg;
    if (div_reg) begin
      if (div_ge) acc_next = {div_diff, acc_reg[WIDTH-2:0], 1'b1};
      else        acc_next = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  assign prod_mag = {{WIDTH{1'b0}}, acc_reg[WIDTH-1:0]} * {{WIDTH{1'b0}}, b_reg};
`else
  assign prod_mag = acc_reg;
`endif

  // Final cycle: restore signs; divide by zero returns all-ones / dividend unchanged
  always_comb begin
    prod = neg_q_reg ? -prod_mag : prod_mag;
    quo  = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem  = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    if (!div_reg) begin
      {res_hi, res_lo} = prod;
    end else if (b_reg == '0) begin
      res_lo = '1;
      res_hi = a_reg;
    end else begin
      res_lo = quo;
      res_hi = rem;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      div_reg   <= 1'b0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      done_reg  <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      done_reg <= last_step;
      if (accept) begin
        cnt_reg   <= (FAST_MUL && !MDOp[1]) ? LAST_STEP : '0;
        div_reg   <= MDOp[1];
        neg_q_reg <= a_neg ^ b_neg;
        neg_r_reg <= a_neg;
        a_reg     <= dInA;
        b_reg     <= b_mag;
        acc_reg   <= {{WIDTH{1'b0}}, a_mag};
      end else if (state_reg == RUN) begin
        if (last_step) begin
          hi_reg <= res_hi;
          lo_reg <= res_lo;
        end else begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + CW'(1);
        end
      end else if (start && (MDOp[2:1] == 2'b10)) begin
        if (MDOp[0]) lo_reg <= dInA;
        else         hi_reg <= dInA;
      end
    end
  end

  assign busy = (state_reg == RUN);
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width; legal values are 8..64, even.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: operation request, sampled on clk.
REQ-005 SHALL have port MDOp, input, 3 bits: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 11x is a no-op.
REQ-006 SHALL have port dInA, input, WIDTH bits: R[rs], the multiplicand or dividend, or the mthi/mtlo data.
REQ-007 SHALL have port dInB, input, WIDTH bits: R[rt], the multiplier or divisor.
REQ-008 SHALL have port busy, output, 1 bit: operation in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when a mult/div result becomes visible on hi/lo.
REQ-010 SHALL have port hi, output, WIDTH bits: HI register.
REQ-011 SHALL have port lo, output, WIDTH bits: LO register.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and RUN; IDLE->RUN on an accepted mult/div; RUN->IDLE when the iteration counter expires.
REQ-013 SHALL accept start only in IDLE; start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-014 SHALL sample dInA, dInB and MDOp on the accepting edge; later input changes SHALL NOT affect the result.
REQ-015 SHALL, for mthi/mtlo accepted in IDLE, write dInA into hi/lo on that edge, with no busy and no done.
REQ-016 SHALL raise busy from the edge after acceptance for exactly N cycles: N=WIDTH+1 for div/divu, and for mult/multu when iterative.
REQ-017 Iterative multiply SHALL be shift-add over WIDTH steps; divide SHALL be restoring over WIDTH steps; both use operand magnitudes, with a final cycle that fixes signs.
REQ-018 mult/multu SHALL give the {hi,lo} 2*WIDTH-bit product, signed or unsigned.
REQ-019 div/divu SHALL set lo=quotient and hi=remainder; the signed quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-020 Divide by zero SHALL give lo=all-ones and hi=dividend, for both signed and unsigned.
REQ-021 Signed div of the most-negative value by -1 SHALL give lo=most-negative value and hi=0.
REQ-022 hi/lo SHALL hold their previous values throughout RUN and update on the edge that ends the last busy cycle.
REQ-023 done SHALL be high for the single cycle after that update, with busy=0 in the same cycle.
REQ-024 A new start SHALL be accepted in the done cycle.

Reset
REQ-025 rst=1 SHALL asynchronously force IDLE, busy=0, done=0, hi=0, lo=0 and clear the counter and internal accumulators.
REQ-026 Reset during RUN SHALL abort the operation with no result written; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-027 Macro MULDIV_FAST_MUL_EN defined: mult/multu SHALL use a single-cycle multiplier with N=1, so done follows the accepting edge by 2 cycles; div timing is unchanged.
REQ-028 Macro MULDIV_FAST_MUL_EN undefined: mult/multu SHALL be iterative with N=WIDTH+1, and no hardware multiplier SHALL be inferred.

Verification
REQ-029 WIDTH=32, mult, A=0xFFFFFFFF, B=2 -> after 33 busy cycles hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulses once.
REQ-030 multu, A=0xFFFFFFFF, B=2 -> hi=0x00000001, lo=0xFFFFFFFE; with MULDIV_FAST_MUL_EN, busy=1 for 1 cycle.
REQ-031 div, A=-7, B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); divu, A=7, B=0 -> lo=0xFFFFFFFF, hi=7.
REQ-032 div, A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0; start pulsed mid-RUN -> ignored, single done.
REQ-033 mtlo A=0x1234 in IDLE -> lo=0x1234 next cycle with busy=0; then div started and rst asserted on busy cycle 10 -> hi=lo=0, busy=0 immediately, and no done.
REQ-034 WIDTH=8, multu, A=0xFF, B=0xFF -> hi=0xFE, lo=0x01 after 9 busy cycles; back-to-back start in the done cycle is accepted.
